dt_scheduler: RTL and testbench
===============================

DT_SCHEDULER -- requirements
Module: dt_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- N_REQ, 4, number of oscillator/model timestep requesters
- DT_WIDTH, `DT_WIDTH, signed fixed-point width of dt values (exponent `DT_EXPONENT)
- TIME_WIDTH, 40, unsigned emulated-time accumulator width
REQ-002 Ports (name, direction, width, meaning):
- emu_clk  in  1  sole clock
- emu_rst  in  1  synchronous, active-high reset
- dt_req  in  N_REQ x DT_WIDTH  signed per-requester timestep requests
- req_en  in  N_REQ  per-requester participation mask
- dt_max  in  DT_WIDTH  global step ceiling, >0
- stop_time  in  TIME_WIDTH  emulated-time halt point; 0 disables it
- run  in  1  level: free-run when high
- step  in  1  one-cycle pulse: single-step request
- emu_dt  out  DT_WIDTH  granted timestep, current cycle
- grant  out  N_REQ  one-hot winner, all-zero when none
- emu_time  out  TIME_WIDTH  accumulated emulated time
- halted  out  1  high in HALT state

Function
REQ-003 States: IDLE, RUN, STEP, HALT.
REQ-004 IDLE->RUN when run=1; IDLE->STEP when step=1 and run=0; otherwise stay in IDLE.
REQ-005 RUN->IDLE when run=0; STEP->IDLE unconditionally after its single cycle.
REQ-006 RUN or STEP->HALT when the granted step makes emu_time reach stop_time (stop_time!=0).
REQ-007 HALT is left only by reset or by stop_time changing to a value > emu_time, then ->IDLE.
REQ-008 Candidate set: enabled requests, with negative dt_req clamped to 0.
REQ-009 dt_min = minimum candidate, capped at dt_max; dt_max when no requester is enabled.
REQ-010 Ties resolve to the lowest index.
REQ-011 In RUN or STEP: emu_dt = min(dt_min, stop_time - emu_time) when stop_time!=0, else dt_min.
REQ-012 In IDLE or HALT: emu_dt = 0 and grant = 0.
REQ-013 emu_dt and grant are combinational from inputs and state: zero latency, same-cycle use by models.
REQ-014 grant marks the requester whose dt_min was used.
REQ-015 grant = 0 when dt_max or the stop truncation set emu_dt below every candidate, or when no requester is enabled.
REQ-016 emu_time <= emu_time + emu_dt each cycle, zero-extended, saturating at 2^TIME_WIDTH-1.
REQ-017 step arriving while in RUN is ignored; run and step high together select RUN.
REQ-018 A zero-valued step (a requester asks 0) is legal: emu_time holds, state is unchanged.
REQ-019 halted is registered from the state and is high in the cycle after entry to HALT.

Reset
REQ-020 emu_rst, sampled on emu_clk, forces state=IDLE, emu_time=0, halted=0; hence emu_dt=0 and grant=0.
REQ-021 Reset asserted mid-RUN abandons the current step: no emu_time update in that cycle.

Structure
REQ-022 Package dt_sched_pkg holds the state enum and the TIME_WIDTH default. DT format macros come from signals.sv.
REQ-023 Sub-module dt_min_tree: combinational N_REQ min-reduction returning value and index, parameterised on N_REQ and DT_WIDTH.
REQ-024 FSM, clamp/truncate logic and accumulator live in dt_scheduler.

Verification
REQ-025 Basic run: reset, run=1, dt_req={5,3,7,3}, req_en=1111, dt_max=10, stop_time=0 -> emu_dt=3, grant=0010 (tie, lowest index), emu_time +3 per cycle.
REQ-026 Cap and mask: dt_req={20,30,-4,50}, req_en=1011, dt_max=10 -> negative request masked out, emu_dt=10, grant=0000.
REQ-027 Stop truncation: emu_time=95, stop_time=100, dt_min=8 -> emu_dt=5, emu_time=100, HALT.
REQ-027a Stop truncation (continued): halted=1 next cycle; emu_dt=0 thereafter until stop_time set to 200 -> IDLE.
REQ-028 Single step: run=0, one-cycle step pulse, dt_min=4 -> exactly one cycle with emu_dt=4, then IDLE with emu_dt=0.
REQ-029 Reset mid-run: emu_rst high during RUN at emu_time=57 -> next cycle emu_time=0, state IDLE, emu_dt=0.
REQ-030 Saturation: TIME_WIDTH=8, emu_time=250, dt=10, stop_time=0 -> emu_time=255 and holds there.

Source files
------------

// File: rtl/dt_sched_pkg.sv
// Common types and defaults for the emulated-time scheduler.
`ifndef DT_WIDTH
`include "signals.sv"
`endif

package dt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } sched_state_e;

    localparam int TIME_WIDTH_DEF = 40;
    localparam int DT_W           = `DT_WIDTH;
    localparam int DT_EXP         = `DT_EXPONENT;

endpackage

// File: rtl/dt_min_tree.sv
// Combinational minimum of the valid dt candidates, with the index of the
// lowest-numbered requester holding that minimum.
module dt_min_tree #(
    parameter int N_REQ    = 4,
    parameter int DT_WIDTH = 16,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0][DT_WIDTH-1:0] val,
    input  logic [N_REQ-1:0]               valid,
    output logic [DT_WIDTH-1:0]            min_val,
    output logic [IDX_W-1:0]               min_idx,
    output logic                           any_valid
);

    // NOTE: every output gets a default before the loop, so no path infers a latch.
    always_comb begin
        min_val   = '0;
        min_idx   = '0;
        any_valid = 1'b0;
        // Strict less-than keeps the earliest index on ties.
        for (int i = 0; i < N_REQ; i++) begin
            if (valid[i] && (!any_valid || val[i] < min_val)) begin
                min_val   = val[i];
                min_idx   = IDX_W'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/signals.sv
// Shared fixed-point format of emulator timestep values (dt).
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif
`ifndef DT_EXPONENT
`define DT_EXPONENT -8
`endif

// File: rtl/dt_scheduler.sv
// Grants one emulated timestep per cycle (smallest request, capped and
// truncated to the stop point) and accumulates emulated time.
module dt_scheduler
    import dt_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = `DT_WIDTH,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF
) (
    input  logic                           emu_clk,
    input  logic                           emu_rst,
    input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]               req_en,
    input  logic [DT_WIDTH-1:0]            dt_max,
    input  logic [TIME_WIDTH-1:0]          stop_time,
    input  logic                           run,
    input  logic                           step,
    output logic [DT_WIDTH-1:0]            emu_dt,
    output logic [N_REQ-1:0]               grant,
    output logic [TIME_WIDTH-1:0]          emu_time,
    output logic                           halted
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Wide enough to hold time plus dt without overflow, whichever is wider.
    localparam int CW = ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;
    localparam logic [CW-1:0] TIME_MAX = CW'({TIME_WIDTH{1'b1}});

    sched_state_e                   state, state_next;
    logic [N_REQ-1:0][DT_WIDTH-1:0] cand;
    logic [DT_WIDTH-1:0]            tree_min, dt_min, dt_sel;
    logic [IDX_W-1:0]               tree_idx;
    logic                           any_en, active, reach;
    logic [CW-1:0]                  time_w, stop_w, rem_w, sum_w;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = dt_req[i][DT_WIDTH-1] ? '0 : dt_req[i];
        end
    end

    dt_min_tree #(
        .N_REQ   (N_REQ),
        .DT_WIDTH(DT_WIDTH)
    ) u_min_tree (
        .val      (cand),
        .valid    (req_en),
        .min_val  (tree_min),
        .min_idx  (tree_idx),
        .any_valid(any_en)
    );

    assign dt_min = (any_en && tree_min < dt_max) ? tree_min : dt_max;
    assign time_w = CW'(emu_time);
    assign stop_w = CW'(stop_time);
    assign rem_w  = (stop_w > time_w) ? stop_w - time_w : '0;
    assign active = (state == ST_RUN) || (state == ST_STEP);

    always_comb begin
        dt_sel = dt_min;
        if (stop_time != '0 && rem_w < CW'(dt_min)) begin
            dt_sel = rem_w[DT_WIDTH-1:0];
        end
        emu_dt = active ? dt_sel : '0;
        grant  = '0;
        // A requester is credited only when its own value is what was granted.
        if (active && any_en && dt_sel == tree_min) begin
            grant[tree_idx] = 1'b1;
        end
    end

    assign sum_w = time_w + CW'(emu_dt);
    assign reach = active && (stop_time != '0) && (sum_w >= stop_w);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (run)       state_next = ST_RUN;
                else if (step) state_next = ST_STEP;
            end
            ST_RUN: begin
                if (reach)     state_next = ST_HALT;
                else if (!run) state_next = ST_IDLE;
            end
            ST_STEP: state_next = reach ? ST_HALT : ST_IDLE;
            ST_HALT: begin
                if (stop_time > emu_time) state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state    <= ST_IDLE;
            emu_time <= '0;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            emu_time <= (sum_w > TIME_MAX) ? TIME_MAX[TIME_WIDTH-1:0] : sum_w[TIME_WIDTH-1:0];
            halted   <= (state_next == ST_HALT);
        end
    end

endmodule

// File: tb/tb_dt_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model of the scheduler.
`timescale 1ns/1ps
module tb_dt_scheduler;
    import dt_sched_pkg::*;

    localparam int N   = 4;
    localparam int DW  = DT_W;
    localparam int TW  = 40;
    localparam int TW8 = 8;
    localparam longint TMAX = (longint'(1) << TW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, run, step;
    logic [N-1:0][DW-1:0]     dt_req;
    logic [N-1:0]             req_en;
    logic [DW-1:0]            dt_max;
    logic [TW-1:0]            stop_time;
    logic [DW-1:0]            emu_dt;
    logic [N-1:0]             grant;
    logic [TW-1:0]            emu_time;
    logic                     halted;

    logic                     s_run;
    logic [N-1:0][DW-1:0]     s_dt_req;
    logic [DW-1:0]            s_emu_dt;
    logic [N-1:0]             s_grant;
    logic [TW8-1:0]           s_emu_time;
    logic                     s_halted;

    dt_scheduler #(.N_REQ(N), .TIME_WIDTH(TW)) u_dut (
        .emu_clk(clk), .emu_rst(rst), .dt_req(dt_req), .req_en(req_en),
        .dt_max(dt_max), .stop_time(stop_time), .run(run), .step(step),
        .emu_dt(emu_dt), .grant(grant), .emu_time(emu_time), .halted(halted)
    );

    dt_scheduler #(.N_REQ(N), .TIME_WIDTH(TW8)) u_sat (
        .emu_clk(clk), .emu_rst(rst), .dt_req(s_dt_req), .req_en(4'b1111),
        .dt_max(DW'(10)), .stop_time(8'd0), .run(s_run), .step(1'b0),
        .emu_dt(s_emu_dt), .grant(s_grant), .emu_time(s_emu_time), .halted(s_halted)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;
    mode_t  m_mode = M_IDLE;
    longint m_time = 0;
    bit     m_known = 1'b0;

    function automatic void model_out(output longint edt, output longint gnt);
        int     best = -1;
        longint bv = 0, c, d, st, rem;
        for (int i = 0; i < N; i++) begin
            if (req_en[i]) begin
                c = $signed(dt_req[i]);
                if (c < 0) c = 0;
                if (best < 0 || c < bv) begin best = i; bv = c; end
            end
        end
        d = longint'(dt_max);
        if (best >= 0 && bv < d) d = bv;
        st = longint'(stop_time);
        if (st != 0) begin
            rem = (st > m_time) ? st - m_time : 0;
            if (rem < d) d = rem;
        end
        if (m_mode == M_RUN || m_mode == M_STEP) begin
            edt = d;
            gnt = (best >= 0 && d == bv) ? (longint'(1) << best) : 0;
        end else begin
            edt = 0;
            gnt = 0;
        end
    endfunction

    always @(negedge clk) begin
        longint edt, gnt, st, nt;
        bit     reach;
        if (m_known) begin
            model_out(edt, gnt);
            check("emu_dt",   emu_dt,   edt);
            check("grant",    grant,    gnt);
            check("emu_time", emu_time, m_time);
            check("halted",   halted,   longint'(m_mode == M_HALT));
        end
        if (rst) begin
            m_mode  = M_IDLE;
            m_time  = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            model_out(edt, gnt);
            st    = longint'(stop_time);
            reach = (m_mode == M_RUN || m_mode == M_STEP) && st != 0 && (m_time + edt >= st);
            nt    = (m_time + edt > TMAX) ? TMAX : m_time + edt;
            case (m_mode)
                M_IDLE: if (run) m_mode = M_RUN; else if (step) m_mode = M_STEP;
                M_RUN:  if (reach) m_mode = M_HALT; else if (!run) m_mode = M_IDLE;
                M_STEP: m_mode = reach ? M_HALT : M_IDLE;
                M_HALT: if (st > m_time) m_mode = M_IDLE;
            endcase
            m_time = nt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int a, input int b, input int c, input int d);
        dt_req[0] = DW'(a);
        dt_req[1] = DW'(b);
        dt_req[2] = DW'(c);
        dt_req[3] = DW'(d);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0;
        set_req(5, 3, 7, 3);
        req_en = 4'b1111; dt_max = DW'(10); stop_time = '0;
        s_run = 1'b0;
        for (int i = 0; i < N; i++) s_dt_req[i] = DW'(10);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_time",   emu_time, 0);
        check("rst_halted", halted,   0);
        check("rst_dt",     emu_dt,   0);
        check("rst_grant",  grant,    0);

        // basic run with a tie between requesters 1 and 3
        run = 1'b1;
        tick();
        check("basic_dt",    emu_dt,   3);
        check("basic_grant", grant,    4'b0010);
        check("basic_t0",    emu_time, 0);
        tick(); check("basic_t1", emu_time, 3);
        tick(); check("basic_t2", emu_time, 6);
        check("model_t2", m_time, 6);

        // cap and mask
        set_req(20, 30, -4, 50); req_en = 4'b1011;
        #1;
        check("cap_dt",    emu_dt, 10);
        check("cap_grant", grant,  0);
        tick(); check("cap_time", emu_time, 16);

        // reset in the middle of a run at emu_time=57
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(19, 19, 19, 19); req_en = 4'b1111; dt_max = DW'(40);
        repeat (4) tick();
        check("mr_pre", emu_time, 57);
        rst = 1'b1;
        tick();
        check("mr_time", emu_time, 0);
        check("mr_dt",   emu_dt,   0);
        rst = 1'b0; run = 1'b0;
        tick();

        // stop truncation 95 -> 100, halt, then release
        stop_time = TW'(100); run = 1'b1;
        tick();
        repeat (5) tick();
        check("st_pre", emu_time, 95);
        set_req(8, 9, 9, 9);
        #1;
        check("st_dt",    emu_dt, 5);
        check("st_grant", grant,  0);
        tick();
        check("st_time",   emu_time, 100);
        check("st_halted", halted,   1);
        check("st_hdt",    emu_dt,   0);
        check("st_hgrant", grant,    0);
        tick();
        check("st_hold_time",   emu_time, 100);
        check("st_hold_halted", halted,   1);
        stop_time = TW'(200);
        tick();
        check("ex_halted", halted, 0);
        check("ex_dt",     emu_dt, 0);
        tick();
        check("res_dt",    emu_dt, 8);
        check("res_grant", grant,  4'b0001);
        run = 1'b0;
        tick();

        // single step from IDLE
        set_req(4, 6, 6, 6);
        step = 1'b1;
        #1; check("sp_idle_dt", emu_dt, 0);
        tick(); step = 1'b0;
        #1;
        check("sp_dt",    emu_dt, 4);
        check("sp_grant", grant,  4'b0001);
        tick();
        check("sp_after_dt", emu_dt,   0);
        check("sp_time",     emu_time, 112);

        // zero-valued request holds time
        set_req(0, 6, 6, 6); run = 1'b1;
        tick(); tick();
        check("z_time",  emu_time, 112);
        check("z_dt",    emu_dt,   0);
        check("z_grant", grant,    4'b0001);
        run = 1'b0;
        tick();

        // saturation on an 8-bit accumulator
        s_run = 1'b1;
        tick();
        repeat (25) tick();
        check("sat_250", s_emu_time, 250);
        tick(); check("sat_255",  s_emu_time, 255);
        tick(); check("sat_hold", s_emu_time, 255);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) run = ~run;
            step = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) dt_req[i] = DW'(int'($urandom_range(0, 48)) - 8);
            end
            if ($urandom_range(0, 7) == 0)  req_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dt_max = DW'($urandom_range(1, 40));
            case ($urandom_range(0, 19))
                0, 1: stop_time = TW'(m_time + longint'($urandom_range(0, 60)));
                2:    stop_time = '0;
                default: ;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
